// File: rtl/fetch_pkg.sv
// Shared constants, queue entry type and counter sizing for the fetch front end.
package fetch_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;
    localparam int PC_STEP  = 4;

    // One fetch-queue slot in the default configuration: instruction plus the PC it came from.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fq_entry_t;

    // Counters must hold every value from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush, used as the fetch queue. Callers
// guarantee it is never pushed when full or popped when empty.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = $bits(fq_entry_t),
    parameter int DEPTH = 4,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage needs no reset; a flush discards the write along with everything else.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Next pointers and occupancy; flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: credit-limited in-order requests, a
// fetch queue of returned instructions, and redirect handling that flushes
// the queue and throws away responses to requests issued before the redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fq_valid,
    input  logic            fq_ready,
    output logic [XLEN-1:0] fq_pc,
    output logic [ILEN-1:0] fq_instr
);

    localparam int CW = cnt_width(FQ_DEPTH);

    // Same shape as fq_entry_t, but sized from this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count;
    logic [CW:0]     occupied;
    logic [XLEN-1:0] redirect_tgt;
    logic            req_fire;
    logic            rsp_keep;
    logic            fq_pop;
    entry_t          push_entry;
    entry_t          head_entry;

    // A request may issue only while queued plus outstanding entries leave room for
    // its response; this is what makes queue overflow impossible.
    assign occupied       = {1'b0, count} + {1'b0, inflight_q};
    assign imem_req_valid = reset & ~redirect_valid & (occupied < (CW+1)'(FQ_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign rsp_keep     = imem_rsp_valid & ~redirect_valid & (drop_q == '0);
    assign fq_valid     = (count != '0);
    assign fq_pop       = fq_valid & fq_ready & ~redirect_valid;

    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign fq_pc      = head_entry.pc;
    assign fq_instr   = head_entry.instr;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_fq (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rsp_keep),
        .pop_i   (fq_pop),
        .flush_i (redirect_valid),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (count)
    );

    // PC, credit and drop bookkeeping; a redirect dooms every outstanding response.
    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d     = redirect_tgt;
            rsp_pc_d = redirect_tgt;
            drop_d   = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(PC_STEP);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // Fetch-state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

endmodule
